// File: rtl/hidden_cpu_sequencer.sv
// hidden_cpu_sequencer: instruction buffer and clock/reset phase sequencer driving the hiddenCPU input bus
module hidden_cpu_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [5:0]    wr_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          step_mode,
    input  logic          step,
    input  logic          halt,
    input  logic [7:0]    cpu_out,
    output logic [7:0]    cpu_in,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   instr_idx,
    output logic [7:0]    last_out,
    output logic          out_valid
);
    typedef enum logic [2:0] {IDLE, RST_LO, RST_HI, SETUP, PULSE, PAUSE, DONE} state_t;

    localparam logic [AW:0] DMAX = (AW+1)'(DEPTH);

    state_t      state;
    logic [5:0]  mem [DEPTH];
    logic [AW:0] len;
    logic [AW:0] idx;
    logic [AW:0] idx1;
    logic [AW:0] plen;
    logic        idle;
    logic        go;
    logic        wr_ok;

    assign idle      = state == IDLE || state == DONE;
    assign busy      = !idle;
    assign go        = !halt && start && idle;
    assign wr_ok     = !rst && !halt && !go && wr_en && idle;
    assign idx1      = idx + 1'b1;
    assign plen      = prog_len > DMAX ? DMAX : prog_len;
    assign instr_idx = idx;

    // buffer storage; contents survive reset and only change between runs
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr] <= wr_data;
    end

    // run sequencer with registered core bus, capture and status
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cpu_in    <= 8'h00;
            done      <= 1'b0;
            idx       <= '0;
            len       <= '0;
            last_out  <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (halt) begin
                if (busy) begin
                    state  <= IDLE;
                    cpu_in <= 8'h00;
                end
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            len    <= plen;
                            idx    <= '0;
                            done   <= plen == '0;
                            state  <= plen == '0 ? DONE : RST_LO;
                            cpu_in <= plen == '0 ? 8'h00 : 8'h02;
                        end else if (wr_en) begin
                            done <= 1'b0;
                        end
                    end
                    RST_LO: begin
                        state  <= RST_HI;
                        cpu_in <= 8'h03;
                    end
                    RST_HI: begin
                        state  <= SETUP;
                        cpu_in <= {mem[idx[AW-1:0]], 2'b00};
                    end
                    SETUP: begin
                        state  <= PULSE;
                        cpu_in <= {cpu_in[7:2], 2'b01};
                    end
                    PULSE: begin
                        last_out  <= cpu_out;
                        out_valid <= 1'b1;
                        idx       <= idx1;
                        if (idx1 == len) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            cpu_in <= 8'h00;
                        end else if (step_mode) begin
                            state  <= PAUSE;
                            cpu_in <= {cpu_in[7:2], 2'b00};
                        end else begin
                            state  <= SETUP;
                            cpu_in <= {mem[idx1[AW-1:0]], 2'b00};
                        end
                    end
                    PAUSE: begin
                        if (step || !step_mode) begin
                            state  <= SETUP;
                            cpu_in <= {mem[idx[AW-1:0]], 2'b00};
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        cpu_in <= 8'h00;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hidden_cpu_sequencer.sv
// tb_hidden_cpu_sequencer: directed self-checking bench for hidden_cpu_sequencer
module tb_hidden_cpu_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [5:0] wr_data = '0;
    logic [4:0] prog_len = '0;
    logic       start = 1'b0;
    logic       step_mode = 1'b0;
    logic       step = 1'b0;
    logic       halt = 1'b0;
    logic [7:0] cpu_out = 8'h00;
    logic [7:0] cpu_in;
    logic       busy;
    logic       done;
    logic [4:0] instr_idx;
    logic [7:0] last_out;
    logic       out_valid;

    int checks = 0;
    int failures = 0;

    hidden_cpu_sequencer #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .prog_len(prog_len), .start(start), .step_mode(step_mode), .step(step), .halt(halt),
        .cpu_out(cpu_out), .cpu_in(cpu_in), .busy(busy), .done(done), .instr_idx(instr_idx),
        .last_out(last_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [5:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick;
        wr_en = 1'b0;
    endtask

    task automatic go(input logic [4:0] n);
        prog_len = n;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    logic [7:0] seq [9] = '{8'h02, 8'h03, 8'h14, 8'h15, 8'h68, 8'h69, 8'hCC, 8'hCD, 8'h00};
    int ov;
    int n;

    initial begin
        tick;
        tick;
        chk("rst_cpu_in", 16'(cpu_in), 16'h00);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_idx", 16'(instr_idx), 16'h0);
        chk("rst_last_out", 16'(last_out), 16'h00);
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        rst = 1'b0;

        wr(4'd0, 6'h05);
        wr(4'd1, 6'h1A);
        wr(4'd2, 6'h33);
        cpu_out = 8'h3C;
        go(5'd3);
        ov = 0;
        chk("seq0", 16'(cpu_in), 16'(seq[0]));
        for (int i = 1; i < 9; i++) begin
            tick;
            if (out_valid) ov++;
            chk($sformatf("seq%0d", i), 16'(cpu_in), 16'(seq[i]));
        end
        chk("seq_done", 16'(done), 16'h1);
        chk("seq_busy", 16'(busy), 16'h0);
        chk("seq_strobes", 16'(ov), 16'd3);
        chk("seq_idx", 16'(instr_idx), 16'd3);
        chk("seq_last_out", 16'(last_out), 16'h3C);

        wr(4'd3, 6'h2F);
        chk("wr_clears_done", 16'(done), 16'h0);

        go(5'd0);
        chk("len0_done", 16'(done), 16'h1);
        chk("len0_busy", 16'(busy), 16'h0);
        chk("len0_cpu_in", 16'(cpu_in), 16'h00);
        tick;
        chk("len0_no_valid", 16'(out_valid), 16'h0);
        chk("len0_cpu_in2", 16'(cpu_in), 16'h00);

        step_mode = 1'b1;
        go(5'd2);
        tick;
        tick;
        tick;
        chk("step_pulse0", 16'(cpu_in), 16'h15);
        tick;
        chk("pause_valid", 16'(out_valid), 16'h1);
        chk("pause_cpu_in", 16'(cpu_in), 16'h14);
        chk("pause_idx", 16'(instr_idx), 16'd1);
        for (int i = 0; i < 4; i++) begin
            start = (i == 1);
            tick;
            chk($sformatf("pause_hold%0d", i), 16'(cpu_in), 16'h14);
            chk($sformatf("pause_busy%0d", i), 16'(busy), 16'h1);
        end
        start = 1'b0;
        chk("pause_idx_after_start", 16'(instr_idx), 16'd1);
        step = 1'b1;
        tick;
        step = 1'b0;
        chk("step_setup1", 16'(cpu_in), 16'h68);
        tick;
        chk("step_pulse1", 16'(cpu_in), 16'h69);
        tick;
        chk("step_done", 16'(done), 16'h1);
        chk("step_idx", 16'(instr_idx), 16'd2);
        step_mode = 1'b0;

        cpu_out = 8'h5A;
        go(5'd4);
        tick;
        tick;
        tick;
        tick;
        tick;
        chk("halt_pre_pulse1", 16'(cpu_in), 16'h69);
        halt = 1'b1;
        cpu_out = 8'h77;
        tick;
        halt = 1'b0;
        chk("halt_cpu_in", 16'(cpu_in), 16'h00);
        chk("halt_idx", 16'(instr_idx), 16'd1);
        chk("halt_done", 16'(done), 16'h0);
        chk("halt_no_valid", 16'(out_valid), 16'h0);
        chk("halt_busy", 16'(busy), 16'h0);
        chk("halt_last_out", 16'(last_out), 16'h5A);

        go(5'd1);
        wr_en = 1'b1;
        wr_addr = 4'd0;
        wr_data = 6'h3F;
        tick;
        tick;
        wr_en = 1'b0;
        chk("busy_wr_setup", 16'(cpu_in), 16'h14);
        tick;
        tick;
        chk("busy_wr_done", 16'(done), 16'h1);
        go(5'd1);
        tick;
        tick;
        chk("busy_wr_rerun", 16'(cpu_in), 16'h14);
        tick;
        tick;

        for (int i = 0; i < 16; i++) wr(4'(i), 6'(i * 5 + 2));
        cpu_out = 8'hA5;
        go(5'd20);
        n = 1;
        ov = 0;
        while (!done && n < 60) begin
            tick;
            n++;
            if (out_valid) ov++;
        end
        chk("clamp_cycles", 16'(n), 16'd35);
        chk("clamp_done", 16'(done), 16'h1);
        chk("clamp_strobes", 16'(ov), 16'd16);
        chk("clamp_idx", 16'(instr_idx), 16'd16);
        chk("clamp_last_out", 16'(last_out), 16'hA5);
        tick;
        chk("valid_one_cycle", 16'(out_valid), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
